arp_frame_gen: RTL and testbench

- Parametrised ARP frame generator; successor to the fixed 32-bit ARP request sender.
- Configured over an Avalon-MM slave; emits complete Ethernet/ARP frames on an Avalon-ST source with a correct ready-latency-0 handshake.
- Supports 32- or 64-bit datapath, REQUEST/REPLY opcode, burst count, inter-frame pause and a frame counter.
- Sits in the test/sim traffic path ahead of the MAC TX FIFO.

---
 rtl/arp_frame_gen_if.sv | 35 +++
 rtl/arp_frame_gen.sv | 194 +++++++++++++++++++
 tb/tb_arp_frame_gen.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_frame_gen_if.sv
// Avalon-MM configuration port plus Avalon-ST frame source for arp_frame_gen.
// slave: the generator's view; master: the host / downstream sink's view.
interface arp_frame_gen_if #(
    parameter int DATA_W = 32
);
    localparam int EMPTY_W = $clog2(DATA_W / 8);

    logic               avs_s0_write;
    logic               avs_s0_read;
    logic [2:0]         avs_s0_address;
    logic [3:0]         avs_s0_byteenable;
    logic [31:0]        avs_s0_writedata;
    logic [31:0]        avs_s0_readdata;

    logic               aso_src0_ready;
    logic [DATA_W-1:0]  aso_src0_data;
    logic               aso_src0_valid;
    logic               aso_src0_startofpacket;
    logic               aso_src0_endofpacket;
    logic [EMPTY_W-1:0] aso_src0_empty;

    modport slave (
        input  avs_s0_write, avs_s0_read, avs_s0_address, avs_s0_byteenable,
               avs_s0_writedata, aso_src0_ready,
        output avs_s0_readdata, aso_src0_data, aso_src0_valid,
               aso_src0_startofpacket, aso_src0_endofpacket, aso_src0_empty
    );

    modport master (
        output avs_s0_write, avs_s0_read, avs_s0_address, avs_s0_byteenable,
               avs_s0_writedata, aso_src0_ready,
        input  avs_s0_readdata, aso_src0_data, aso_src0_valid,
               aso_src0_startofpacket, aso_src0_endofpacket, aso_src0_empty
    );
endinterface

// File: rtl/arp_frame_gen.sv
// Parametrised Ethernet/ARP frame generator (MM-configured, ST source, ready latency 0).
// Define ARP_FRAME_GEN_PAD_EN to zero-pad frames to the 60-byte Ethernet minimum.
module arp_frame_gen #(
    parameter int DATA_W  = 32,
    parameter int PAUSE_W = 16,
    parameter int CNT_W   = 32
) (
    input  logic           csi_clock_clk,
    input  logic           csi_clock_reset,
    arp_frame_gen_if.slave bus
);
    localparam int EMPTY_W = $clog2(DATA_W / 8);
`ifdef ARP_FRAME_GEN_PAD_EN
    localparam int FRAME_BYTES = 60;
`else
    localparam int FRAME_BYTES = 42;
`endif
    localparam int BEATS  = (FRAME_BYTES * 8 + DATA_W - 1) / DATA_W;
    localparam int VEC_W  = BEATS * DATA_W;
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [EMPTY_W-1:0] EOP_EMPTY = EMPTY_W'(BEATS * DATA_W / 8 - FRAME_BYTES);
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, SEND, PAUSE} state_t;
    state_t state, state_nxt;

    logic [31:0]        ctrl;
    logic [47:0]        mac_dst, mac_src;
    logic [31:0]        ip_src, ip_dst;
    logic [CNT_W-1:0]   frame_cnt;

    logic [47:0]        sh_mac_dst, sh_mac_src;
    logic [31:0]        sh_ip_src, sh_ip_dst;
    logic               sh_oper;

    logic [BEAT_W-1:0]  beat_idx;
    logic [7:0]         burst_rem;
    logic               burst_armed;
    logic [PAUSE_W-1:0] pause_cnt;

    logic               go, start, last_acc, go_hw_clr, valid;
    logic [7:0]         burst_val;
    logic [PAUSE_W-1:0] pause_val;

    assign go        = ctrl[0];
    assign burst_val = ctrl[15:8];
    assign pause_val = ctrl[16 +: PAUSE_W];
    assign valid     = (state == SEND);
    assign go_hw_clr = last_acc && (burst_rem == 8'd1);

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[i*8 +: 8] = be[i] ? wdata[i*8 +: 8] : old_val[i*8 +: 8];
        return res;
    endfunction

    always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
        // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
        if (csi_clock_reset) state <= IDLE;
        else                 state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_nxt = state;
        start     = 1'b0;
        last_acc  = 1'b0;
        unique case (state)
            IDLE: if (go) begin
                state_nxt = SEND;
                start     = 1'b1;
            end
            SEND: if (bus.aso_src0_ready && beat_idx == LAST_BEAT) begin
                last_acc  = 1'b1;
                state_nxt = (pause_val != '0) ? PAUSE : IDLE;
            end
            PAUSE: if (pause_cnt <= PAUSE_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-frame datapath: config snapshot, beat index, burst and pause counters.
    always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
        if (csi_clock_reset) begin
            sh_mac_dst  <= '0;
            sh_mac_src  <= '0;
            sh_ip_src   <= '0;
            sh_ip_dst   <= '0;
            sh_oper     <= 1'b0;
            beat_idx    <= '0;
            burst_rem   <= '0;
            burst_armed <= 1'b0;
            pause_cnt   <= '0;
        end else begin
            if (start) begin
                sh_mac_dst <= mac_dst;
                sh_mac_src <= mac_src;
                sh_ip_src  <= ip_src;
                sh_ip_dst  <= ip_dst;
                sh_oper    <= ctrl[1];
                beat_idx   <= '0;
                if (!burst_armed) begin
                    burst_rem   <= burst_val;
                    burst_armed <= 1'b1;
                end
            end else if (valid && bus.aso_src0_ready) begin
                beat_idx <= (beat_idx == LAST_BEAT) ? '0 : beat_idx + BEAT_W'(1);
            end

            if (last_acc) begin
                pause_cnt <= pause_val;
                if (burst_rem > 8'd1) burst_rem <= burst_rem - 8'd1;
            end else if (state == PAUSE) begin
                pause_cnt <= pause_cnt - PAUSE_W'(1);
            end

            // A burst re-arms (reloads its count) once go has dropped.
            if (!go || go_hw_clr) burst_armed <= 1'b0;
        end
    end

    // Register file; later assignments win, so a software CTRL write beats the hardware go clear.
    always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
        if (csi_clock_reset) begin
            ctrl      <= '0;
            mac_dst   <= '0;
            mac_src   <= '0;
            ip_src    <= '0;
            ip_dst    <= '0;
            frame_cnt <= '0;
        end else begin
            if (go_hw_clr) ctrl[0] <= 1'b0;
            if (last_acc)  frame_cnt <= frame_cnt + CNT_W'(1);
            if (bus.avs_s0_write) begin
                unique case (bus.avs_s0_address)
                    3'd0: ctrl           <= be_merge(ctrl, bus.avs_s0_writedata, bus.avs_s0_byteenable);
                    3'd1: mac_dst[47:16] <= be_merge(mac_dst[47:16], bus.avs_s0_writedata, bus.avs_s0_byteenable);
                    3'd2: mac_dst[15:0]  <= 16'(be_merge({16'h0, mac_dst[15:0]}, bus.avs_s0_writedata, bus.avs_s0_byteenable));
                    3'd3: mac_src[47:16] <= be_merge(mac_src[47:16], bus.avs_s0_writedata, bus.avs_s0_byteenable);
                    3'd4: mac_src[15:0]  <= 16'(be_merge({16'h0, mac_src[15:0]}, bus.avs_s0_writedata, bus.avs_s0_byteenable));
                    3'd5: ip_src         <= be_merge(ip_src, bus.avs_s0_writedata, bus.avs_s0_byteenable);
                    3'd6: ip_dst         <= be_merge(ip_dst, bus.avs_s0_writedata, bus.avs_s0_byteenable);
                    3'd7: frame_cnt      <= '0;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.avs_s0_readdata = '0;
        if (bus.avs_s0_read) begin
            unique case (bus.avs_s0_address)
                3'd0: bus.avs_s0_readdata = ctrl;
                3'd1: bus.avs_s0_readdata = mac_dst[47:16];
                3'd2: bus.avs_s0_readdata = {16'h0, mac_dst[15:0]};
                3'd3: bus.avs_s0_readdata = mac_src[47:16];
                3'd4: bus.avs_s0_readdata = {16'h0, mac_src[15:0]};
                3'd5: bus.avs_s0_readdata = ip_src;
                3'd6: bus.avs_s0_readdata = ip_dst;
                3'd7: bus.avs_s0_readdata = 32'(frame_cnt);
                default: ;
            endcase
        end
    end

    // Whole frame as one big-endian vector, tail zero-filled up to a beat boundary.
    logic [335:0]      arp_hdr;
    logic [VEC_W-1:0]  frame_vec;
    logic [DATA_W-1:0] beat_word [BEATS];

    assign arp_hdr = {sh_oper ? sh_mac_dst : 48'hFFFF_FFFF_FFFF, sh_mac_src,
                      16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4,
                      sh_oper ? 16'h0002 : 16'h0001,
                      sh_mac_src, sh_ip_src,
                      sh_oper ? sh_mac_dst : 48'h0, sh_ip_dst};
    assign frame_vec = {arp_hdr, {(VEC_W - 336){1'b0}}};

    always_comb begin
        for (int i = 0; i < BEATS; i++)
            beat_word[i] = frame_vec[VEC_W - 1 - i * DATA_W -: DATA_W];
    end

    always_comb begin
        bus.aso_src0_valid         = valid;
        bus.aso_src0_data          = valid ? beat_word[beat_idx] : '0;
        bus.aso_src0_startofpacket = valid && (beat_idx == '0);
        bus.aso_src0_endofpacket   = valid && (beat_idx == LAST_BEAT);
        bus.aso_src0_empty         = (valid && beat_idx == LAST_BEAT) ? EOP_EMPTY : '0;
    end
endmodule

// File: tb/tb_arp_frame_gen.sv
// Self-checking bench for arp_frame_gen: register table, directed frame sequences
// and randomized configs/backpressure compared against a byte-level frame model.
module tb_arp_frame_gen;
    localparam int DATA_W  = 32;
    localparam int EMPTY_W = $clog2(DATA_W / 8);
    localparam int BPB     = DATA_W / 8;
`ifdef ARP_FRAME_GEN_PAD_EN
    localparam int MIN_BYTES = 60;
`else
    localparam int MIN_BYTES = 42;
`endif
    localparam int BUDGET = 400;

    typedef struct {
        logic [47:0] mac_dst;
        logic [47:0] mac_src;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic        oper;
    } cfg_t;

    typedef struct {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } beat_t;

    typedef struct {
        logic [2:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } reg_vec_t;

    logic  csi_clock_clk   = 1'b0;
    logic  csi_clock_reset = 1'b1;
    int    errors = 0;
    int    checks = 0;
    int    cnt_exp = 0;
    beat_t got[$];
    beat_t exp_q[$];

    arp_frame_gen_if #(.DATA_W(DATA_W)) bus ();
    arp_frame_gen #(.DATA_W(DATA_W)) dut (
        .csi_clock_clk  (csi_clock_clk),
        .csi_clock_reset(csi_clock_reset),
        .bus            (bus)
    );

    always #5 csi_clock_clk = ~csi_clock_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: lay the frame out byte by byte, then cut it into beats.
    function automatic void model_frame(input cfg_t c);
        logic [7:0] b[$];
        int         nbeats;
        beat_t      bt;
        for (int i = 5; i >= 0; i--) b.push_back(c.oper ? c.mac_dst[i*8 +: 8] : 8'hFF);
        for (int i = 5; i >= 0; i--) b.push_back(c.mac_src[i*8 +: 8]);
        b.push_back(8'h08); b.push_back(8'h06);
        b.push_back(8'h00); b.push_back(8'h01);
        b.push_back(8'h08); b.push_back(8'h00);
        b.push_back(8'h06); b.push_back(8'h04);
        b.push_back(8'h00); b.push_back(c.oper ? 8'h02 : 8'h01);
        for (int i = 5; i >= 0; i--) b.push_back(c.mac_src[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) b.push_back(c.ip_src[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) b.push_back(c.oper ? c.mac_dst[i*8 +: 8] : 8'h00);
        for (int i = 3; i >= 0; i--) b.push_back(c.ip_dst[i*8 +: 8]);
        while (b.size() < MIN_BYTES) b.push_back(8'h00);
        nbeats = (b.size() + BPB - 1) / BPB;
        exp_q.delete();
        for (int k = 0; k < nbeats; k++) begin
            bt.data = '0;
            for (int j = 0; j < BPB; j++)
                if (k * BPB + j < b.size()) bt.data[DATA_W - 1 - 8 * j -: 8] = b[k * BPB + j];
            bt.sop   = (k == 0);
            bt.eop   = (k == nbeats - 1);
            bt.empty = bt.eop ? EMPTY_W'(nbeats * BPB - b.size()) : '0;
            exp_q.push_back(bt);
        end
    endfunction

    task automatic compare_frame(input string tag, input cfg_t c);
        int n;
        model_frame(c);
        check($sformatf("%s_len", tag), 64'(got.size()), 64'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_b%0d_data", tag, k), 64'(got[k].data), 64'(exp_q[k].data));
            check($sformatf("%s_b%0d_sop", tag, k), 64'(got[k].sop), 64'(exp_q[k].sop));
            check($sformatf("%s_b%0d_eop", tag, k), 64'(got[k].eop), 64'(exp_q[k].eop));
            check($sformatf("%s_b%0d_empty", tag, k), 64'(got[k].empty), 64'(exp_q[k].empty));
        end
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic mm_write(input logic [2:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus.avs_s0_write      = 1'b1;
        bus.avs_s0_address    = addr;
        bus.avs_s0_writedata  = data;
        bus.avs_s0_byteenable = be;
        @(posedge csi_clock_clk); #1;
        bus.avs_s0_write = 1'b0;
    endtask

    task automatic mm_read(input logic [2:0] addr, output logic [31:0] data);
        bus.avs_s0_read    = 1'b1;
        bus.avs_s0_address = addr;
        @(negedge csi_clock_clk);
        data = bus.avs_s0_readdata;
        @(posedge csi_clock_clk); #1;
        bus.avs_s0_read = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [2:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        mm_read(addr, rd);
        check(name, 64'(rd), 64'(exp));
    endtask

    task automatic write_cfg(input cfg_t c);
        mm_write(3'd1, c.mac_dst[47:16], 4'hF);
        mm_write(3'd2, {16'h0, c.mac_dst[15:0]}, 4'hF);
        mm_write(3'd3, c.mac_src[47:16], 4'hF);
        mm_write(3'd4, {16'h0, c.mac_src[15:0]}, 4'hF);
        mm_write(3'd5, c.ip_src, 4'hF);
        mm_write(3'd6, c.ip_dst, 4'hF);
    endtask

    function automatic logic [31:0] ctrl_word(input logic go, input logic oper,
                                              input logic [7:0] burst, input logic [15:0] pause);
        return {pause, burst, 6'b0, oper, go};
    endfunction

    // Collects one frame of accepted beats; checks hold-under-backpressure on the way.
    // gap = valid=0 cycles seen before the first beat; optional MM write at a given beat.
    task automatic collect_frame(input bit rnd_ready, input int abort_at, input bit inj_en,
                                 input int inj_beat, input logic [2:0] inj_addr,
                                 input logic [31:0] inj_data, output int gap);
        beat_t cur, prev;
        bit    prev_stall = 1'b0;
        bit    done = 1'b0;
        bit    injected = 1'b0;
        int    cyc = 0;
        got.delete();
        gap  = 0;
        prev = '{default: '0};
        while (!done) begin
            bus.aso_src0_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (inj_en && !injected && got.size() == inj_beat) begin
                bus.avs_s0_write      = 1'b1;
                bus.avs_s0_address    = inj_addr;
                bus.avs_s0_writedata  = inj_data;
                bus.avs_s0_byteenable = 4'hF;
                injected = 1'b1;
            end else begin
                bus.avs_s0_write = 1'b0;
            end
            @(negedge csi_clock_clk);
            cur.data  = bus.aso_src0_data;
            cur.sop   = bus.aso_src0_startofpacket;
            cur.eop   = bus.aso_src0_endofpacket;
            cur.empty = bus.aso_src0_empty;
            if (prev_stall) begin
                check("hold_valid", 64'(bus.aso_src0_valid), 64'(1));
                check("hold_data", 64'(cur.data), 64'(prev.data));
                check("hold_sop_eop", 64'({cur.sop, cur.eop}), 64'({prev.sop, prev.eop}));
                check("hold_empty", 64'(cur.empty), 64'(prev.empty));
            end
            if (bus.aso_src0_valid) begin
                prev_stall = !bus.aso_src0_ready;
                prev       = cur;
                if (bus.aso_src0_ready) begin
                    got.push_back(cur);
                    if (cur.eop) done = 1'b1;
                end
            end else begin
                prev_stall = 1'b0;
                if (got.size() == 0) gap++;
            end
            if (abort_at > 0 && got.size() == abort_at) done = 1'b1;
            cyc++;
            if (!done && cyc > BUDGET) begin
                check("frame_timeout", 64'(1), 64'(0));
                done = 1'b1;
            end
            @(posedge csi_clock_clk); #1;
        end
        bus.avs_s0_write   = 1'b0;
        bus.aso_src0_ready = 1'b0;
    endtask

    task automatic expect_idle(input string name, input int n);
        int seen = 0;
        repeat (n) begin
            @(negedge csi_clock_clk);
            if (bus.aso_src0_valid) seen++;
            @(posedge csi_clock_clk); #1;
        end
        check(name, 64'(seen), 64'(0));
    endtask

    initial begin
        reg_vec_t    tbl[10];
        cfg_t        c0, c1, cr;
        int          gap;
        logic [31:0] rd;

        tbl[0] = '{3'd1, 4'hF,    32'hAABBCCDD, 32'hAABBCCDD};
        tbl[1] = '{3'd2, 4'h3,    32'h1234EEFF, 32'h0000EEFF};
        tbl[2] = '{3'd1, 4'b0101, 32'h11223344, 32'hAA22CC44};
        tbl[3] = '{3'd5, 4'hF,    32'h0A000001, 32'h0A000001};
        tbl[4] = '{3'd6, 4'hF,    32'h0A000002, 32'h0A000002};
        tbl[5] = '{3'd3, 4'hF,    32'h02000000, 32'h02000000};
        tbl[6] = '{3'd4, 4'hF,    32'h00000001, 32'h00000001};
        tbl[7] = '{3'd2, 4'b1100, 32'hFFFF0000, 32'h0000EEFF};
        tbl[8] = '{3'd0, 4'b1110, 32'h000503FF, 32'h00050300};
        tbl[9] = '{3'd7, 4'hF,    32'h12345678, 32'h00000000};

        bus.avs_s0_write      = 1'b0;
        bus.avs_s0_read       = 1'b0;
        bus.avs_s0_address    = '0;
        bus.avs_s0_byteenable = '0;
        bus.avs_s0_writedata  = '0;
        bus.aso_src0_ready    = 1'b0;

        #23 csi_clock_reset = 1'b0;
        @(posedge csi_clock_clk); #1;

        // Reset state
        @(negedge csi_clock_clk);
        check("rst_valid", 64'(bus.aso_src0_valid), 64'(0));
        check("rst_data", 64'(bus.aso_src0_data), 64'(0));
        check("rst_sop_eop", 64'({bus.aso_src0_startofpacket, bus.aso_src0_endofpacket}), 64'(0));
        check("rst_empty", 64'(bus.aso_src0_empty), 64'(0));
        @(posedge csi_clock_clk); #1;
        for (int a = 0; a < 8; a++) read_check($sformatf("rst_reg%0d", a), 3'(a), 32'h0);

        // Register table with byte-enable masking
        for (int i = 0; i < 10; i++) begin
            mm_write(tbl[i].addr, tbl[i].wdata, tbl[i].be);
            read_check($sformatf("reg_tbl%0d", i), tbl[i].addr, tbl[i].exp_rd);
        end
        expect_idle("no_start_without_go", 10);

        // REQUEST frame, ready held high
        c0 = '{mac_dst: 48'h0, mac_src: 48'h020000000001, ip_src: 32'h0A000001,
               ip_dst: 32'h0A000002, oper: 1'b0};
        write_cfg(c0);
        mm_write(3'd0, ctrl_word(1'b1, 1'b0, 8'd1, 16'd0), 4'hF);
        collect_frame(1'b0, 0, 1'b0, 0, 3'd0, 32'h0, gap);
        cnt_exp++;
        compare_frame("req", c0);
        mm_read(3'd0, rd);
        check("req_go_cleared", 64'(rd[0]), 64'(0));
        read_check("req_cnt", 3'd7, 32'(cnt_exp));

        // REPLY frame
        c1 = c0;
        c1.oper    = 1'b1;
        c1.mac_dst = 48'hAABBCCDDEEFF;
        write_cfg(c1);
        mm_write(3'd0, ctrl_word(1'b1, 1'b1, 8'd1, 16'd0), 4'hF);
        collect_frame(1'b0, 0, 1'b0, 0, 3'd0, 32'h0, gap);
        cnt_exp++;
        compare_frame("rep", c1);
        read_check("rep_cnt", 3'd7, 32'(cnt_exp));

        // Randomized configs with random backpressure
        for (int it = 0; it < 4; it++) begin
            cr.mac_dst = {16'($urandom), $urandom};
            cr.mac_src = {16'($urandom), $urandom};
            cr.ip_src  = $urandom;
            cr.ip_dst  = $urandom;
            cr.oper    = 1'($urandom_range(0, 1));
            write_cfg(cr);
            mm_write(3'd0, ctrl_word(1'b1, cr.oper, 8'd1, 16'd0), 4'hF);
            collect_frame(1'b1, 0, 1'b0, 0, 3'd0, 32'h0, gap);
            cnt_exp++;
            compare_frame($sformatf("rnd%0d", it), cr);
            read_check($sformatf("rnd%0d_cnt", it), 3'd7, 32'(cnt_exp));
        end

        // Burst of 3 with pause 5: gap of 6 idle cycles, then go self-clears
        write_cfg(c0);
        mm_write(3'd7, 32'h0, 4'hF);
        cnt_exp = 0;
        mm_write(3'd0, ctrl_word(1'b1, 1'b0, 8'd3, 16'd5), 4'hF);
        for (int f = 0; f < 3; f++) begin
            collect_frame(1'b0, 0, 1'b0, 0, 3'd0, 32'h0, gap);
            cnt_exp++;
            compare_frame($sformatf("burst_f%0d", f), c0);
            if (f > 0) check($sformatf("burst_gap%0d", f), 64'(gap), 64'(6));
        end
        expect_idle("burst_stops", 30);
        mm_read(3'd0, rd);
        check("burst_go_cleared", 64'(rd[0]), 64'(0));
        read_check("burst_cnt", 3'd7, 32'(cnt_exp));

        // ip_dst write mid-frame only affects the next frame
        mm_write(3'd0, ctrl_word(1'b1, 1'b0, 8'd2, 16'd0), 4'hF);
        collect_frame(1'b0, 0, 1'b1, 4, 3'd6, 32'hC0A80001, gap);
        cnt_exp++;
        compare_frame("snap_f0", c0);
        collect_frame(1'b0, 0, 1'b0, 0, 3'd0, 32'h0, gap);
        cnt_exp++;
        c1 = c0;
        c1.ip_dst = 32'hC0A80001;
        compare_frame("snap_f1", c1);
        check("snap_gap", 64'(gap), 64'(1));
        read_check("snap_cnt", 3'd7, 32'(cnt_exp));

        // Continuous mode, go cleared mid-frame: frame completes, nothing follows
        write_cfg(c0);
        mm_write(3'd0, ctrl_word(1'b1, 1'b0, 8'd0, 16'd2), 4'hF);
        collect_frame(1'b1, 0, 1'b1, 3, 3'd0, ctrl_word(1'b0, 1'b0, 8'd0, 16'd2), gap);
        cnt_exp++;
        compare_frame("goclr", c0);
        expect_idle("goclr_stops", 30);
        read_check("goclr_cnt", 3'd7, 32'(cnt_exp));

        // Reset mid-frame: valid drops asynchronously, registers and counter cleared
        mm_write(3'd7, 32'h0, 4'hF);
        mm_write(3'd0, ctrl_word(1'b1, 1'b0, 8'd1, 16'd0), 4'hF);
        collect_frame(1'b0, 6, 1'b0, 0, 3'd0, 32'h0, gap);
        check("prerst_valid", 64'(bus.aso_src0_valid), 64'(1));
        csi_clock_reset = 1'b1;
        #2;
        check("arst_valid", 64'(bus.aso_src0_valid), 64'(0));
        check("arst_data", 64'(bus.aso_src0_data), 64'(0));
        check("arst_eop", 64'(bus.aso_src0_endofpacket), 64'(0));
        @(posedge csi_clock_clk);
        @(posedge csi_clock_clk); #1;
        csi_clock_reset = 1'b0;
        read_check("arst_ctrl", 3'd0, 32'h0);
        read_check("arst_cnt", 3'd7, 32'h0);
        read_check("arst_ipdst", 3'd6, 32'h0);
        expect_idle("arst_idle", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
